// File: rtl/dump_pkg.sv
// Shared definitions for the post-halt memory dump controller:
// FSM state encodings, the two halt instruction encodings and the
// default drain interval.
package dump_pkg;

    // State register encoding (plain constants so legacy tooling that
    // dumps the raw state vector keeps working).
    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_DRAIN = 3'd1;
    localparam state_t S_RD    = 3'd2;
    localparam state_t S_CHK   = 3'd3;
    localparam state_t S_EMIT  = 3'd4;
    localparam state_t S_DONE  = 3'd5;

    // Both encodings the core uses for "halt".
    localparam logic [15:0] HALT_A = 16'b11100_00000000000;
    localparam logic [15:0] HALT_B = 16'b1110011111111111;

    // Cycles the pipeline needs to drain before memory is consistent.
    localparam int DRAIN_CYCLES_DEF = 10;

    // True when an instruction word matches either halt encoding.
    function automatic logic is_halt(input logic [15:0] instr);
        return (instr == HALT_A) || (instr == HALT_B);
    endfunction

endpackage

// File: rtl/halt_detect.sv
// Halt detector: compares the issued instruction against both halt
// encodings. 'hit' is the same-cycle match (only while armed, i.e. the
// controller is idle); 'halted' is the registered sticky flag.
module halt_detect
    import dump_pkg::*;
#(
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    input  logic               arm,
    output logic               hit,
    output logic               halted
);

    localparam logic [INSTR_W-1:0] HA = INSTR_W'(HALT_A);
    localparam logic [INSTR_W-1:0] HB = INSTR_W'(HALT_B);

    // Only a real issued instruction can trigger, and only while armed.
    assign hit = arm && instr_valid && ((instr == HA) || (instr == HB));

    // Sticky halted flag; reset has priority over a coincident halt.
    always_ff @(posedge clk) begin
        if (!reset)
            halted <= 1'b0;
        else if (hit)
            halted <= 1'b1;
    end

endmodule

// File: rtl/halt_dump_ctrl.sv
// Post-halt memory dump controller. After a halt is seen it waits
// DRAIN_CYCLES for the pipeline to empty, then reads data memory from
// address 0 to LAST_ADDR, emitting words on a ready/valid stream.
// Optional build macro DUMP_SKIP_ZERO_EN: zero words are skipped
// (neither emitted nor counted). Without it every address is emitted.
module halt_dump_ctrl
    import dump_pkg::*;
#(
    parameter int          DATA_W       = 16,
    parameter int          INSTR_W      = 16,
    parameter int          ADDR_W       = 16,
    parameter int unsigned LAST_ADDR    = 2**ADDR_W - 1,
    parameter int          DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               instr_valid_i,
    output logic               mem_rd_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic [DATA_W-1:0]  mem_rdata_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [ADDR_W-1:0]  out_addr_o,
    output logic [DATA_W-1:0]  out_data_o,
    output logic               halted_o,
    output logic               done_o,
    output logic [ADDR_W:0]    word_count_o
);

    localparam int               CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(LAST_ADDR);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   drain_cnt;
    logic [ADDR_W-1:0]  scan_addr;
    logic               hit;
    logic               last;
    logic               skip;

    halt_detect #(
        .INSTR_W (INSTR_W)
    ) u_halt_detect (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr_i),
        .instr_valid (instr_valid_i),
        .arm         (state == S_IDLE),
        .hit         (hit),
        .halted      (halted_o)
    );

    assign last = (scan_addr == LAST_A);

`ifdef DUMP_SKIP_ZERO_EN
    assign skip = (mem_rdata_i == '0);
`else
    assign skip = 1'b0;
`endif

    // Next-state logic; the scan ends on LAST_ADDR instead of wrapping.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (hit) state_nx = S_DRAIN;
            S_DRAIN: if (drain_cnt == DRAIN_LAST) state_nx = S_RD;
            S_RD:    state_nx = S_CHK;
            S_CHK: begin
                if (!skip)
                    state_nx = S_EMIT;
                else
                    state_nx = last ? S_DONE : S_RD;
            end
            S_EMIT:  if (out_ready_i) state_nx = last ? S_DONE : S_RD;
            S_DONE:  state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Drain counter, scan address, output word capture and word count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            drain_cnt    <= '0;
            scan_addr    <= '0;
            out_addr_o   <= '0;
            out_data_o   <= '0;
            word_count_o <= '0;
        end else begin
            case (state)
                S_IDLE: drain_cnt <= '0;
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (drain_cnt == DRAIN_LAST)
                        scan_addr <= '0;
                end
                S_CHK: begin
                    // Capture once; held stable for the whole EMIT phase.
                    out_data_o <= mem_rdata_i;
                    out_addr_o <= scan_addr;
                    if (skip && !last)
                        scan_addr <= scan_addr + 1'b1;
                end
                S_EMIT: begin
                    if (out_ready_i) begin
                        word_count_o <= word_count_o + 1'b1;
                        if (!last)
                            scan_addr <= scan_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes are pure state decodes of a registered state, so each is
    // glitch-free and a read lasts exactly one cycle.
    assign mem_rd_o    = (state == S_RD);
    assign mem_addr_o  = scan_addr;
    assign out_valid_o = (state == S_EMIT);
    assign done_o      = (state == S_DONE);

endmodule
